// File: rtl/fib_sweep_ctrl.sv
// fib_sweep_ctrl: sweeps n over [lo_n, hi_n], starts the Fibonacci core for each n,
// captures the result, checks it against the running recurrence and queues
// {n, value, err} in a small FIFO for a valid/ready consumer.
module fib_sweep_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [3:0]  lo_n,
  input  logic [3:0]  hi_n,
  output logic        fib_start,
  output logic [3:0]  fib_n,
  input  logic        fib_ready,
  input  logic [10:0] fib_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_n,
  output logic [10:0] res_data,
  output logic        res_err,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        bad_cfg,
  output logic [3:0]  err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_PUSH
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [3:0]       r_cur;
  logic [3:0]       r_hi;
  logic [10:0]      r_cap;
  logic             r_capErr;
  logic [10:0]      r_p1;
  logic [10:0]      r_p2;
  logic [1:0]       r_histCnt;
  logic [3:0]       r_errCount;
  logic [TMO_W-1:0] r_waitCnt;
  logic             r_timeout;
  logic             r_done;
  logic             r_badCfg;
  logic             r_fibStart;

  logic [3:0]       r_memN    [DEPTH];
  logic [10:0]      r_memData [DEPTH];
  logic             r_memErr  [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic        w_goOk;
  logic [11:0] w_sum;
  logic        w_capErr;
  logic        w_capture;
  logic        w_waitExpired;
  logic        w_abort;
  logic        w_push;
  logic        w_pop;
  logic        w_lastN;

  assign res_valid = (r_count != '0);
  assign res_n     = res_valid ? r_memN[r_rdPtr]    : '0;
  assign res_data  = res_valid ? r_memData[r_rdPtr] : '0;
  assign res_err   = res_valid ? r_memErr[r_rdPtr]  : 1'b0;
  assign busy      = (r_state != S_IDLE);
  assign fib_start = r_fibStart;
  assign fib_n     = r_cur;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign bad_cfg   = r_badCfg;
  assign err_count = r_errCount;

  // Decode the conditions shared by the FSM and the datapath registers.
  always_comb begin
    w_goOk        = go && (lo_n >= 4'd2) && (lo_n <= hi_n);
    w_sum         = {1'b0, r_p1} + {1'b0, r_p2};
    w_capErr      = (r_histCnt == 2'd2) && ({1'b0, fib_out} != w_sum);
    w_capture     = (r_state == S_WAIT_DONE) && fib_ready;
    w_waitExpired = (r_waitCnt == TMO_W'(TIMEOUT - 1));
    w_abort       = w_waitExpired &&
                    (((r_state == S_WAIT_BUSY) && fib_ready) ||
                     ((r_state == S_WAIT_DONE) && !fib_ready));
    w_push        = (r_state == S_PUSH) && (r_count < CNT_W'(DEPTH));
    w_pop         = res_valid && res_ready;
    w_lastN       = (r_cur == r_hi);
  end

  // Next-state logic: a wait that outlives its budget drops back to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:      if (w_goOk) w_nextState = S_ISSUE;
      S_ISSUE:     w_nextState = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!fib_ready)         w_nextState = S_WAIT_DONE;
        else if (w_waitExpired) w_nextState = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (fib_ready)          w_nextState = S_PUSH;
        else if (w_waitExpired) w_nextState = S_IDLE;
      end
      S_PUSH:      if (w_push) w_nextState = w_lastN ? S_IDLE : S_ISSUE;
      default:     w_nextState = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Cycle counter for the two core-wait states; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_waitCnt <= '0;
    else if ((w_nextState == r_state) &&
             ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)))
      r_waitCnt <= r_waitCnt + TMO_W'(1);
    else
      r_waitCnt <= '0;
  end

  // Sweep bookkeeping plus the registered start/done/bad_cfg pulses and sticky timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur      <= '0;
      r_hi       <= '0;
      r_timeout  <= 1'b0;
      r_fibStart <= 1'b0;
      r_done     <= 1'b0;
      r_badCfg   <= 1'b0;
    end else begin
      r_fibStart <= (w_nextState == S_ISSUE);
      r_done     <= w_push && w_lastN;
      r_badCfg   <= (r_state == S_IDLE) && go && !w_goOk;
      if ((r_state == S_IDLE) && w_goOk) begin
        r_cur     <= lo_n;
        r_hi      <= hi_n;
        r_timeout <= 1'b0;
      end
      if (w_abort)
        r_timeout <= 1'b1;
      if (w_push && !w_lastN)
        r_cur <= r_cur + 4'd1;
    end
  end

  // Result capture and recurrence history; corrupted values still enter the history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap      <= '0;
      r_capErr   <= 1'b0;
      r_p1       <= '0;
      r_p2       <= '0;
      r_histCnt  <= '0;
      r_errCount <= '0;
    end else if ((r_state == S_IDLE) && w_goOk) begin
      r_p1       <= '0;
      r_p2       <= '0;
      r_histCnt  <= '0;
      r_errCount <= '0;
    end else if (w_capture) begin
      r_cap    <= fib_out;
      r_capErr <= w_capErr;
      r_p2     <= r_p1;
      r_p1     <= fib_out;
      if (r_histCnt != 2'd2)
        r_histCnt <= r_histCnt + 2'd1;
      if (w_capErr && (r_errCount != 4'd15))
        r_errCount <= r_errCount + 4'd1;
    end
  end

  // FIFO pointers and occupancy; a push is only allowed when not full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only observed while the count says they are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memN[r_wrPtr]    <= r_cur;
      r_memData[r_wrPtr] <= r_cap;
      r_memErr[r_wrPtr]  <= r_capErr;
    end
  end

endmodule

// File: tb/tb_fib_sweep_ctrl.sv
// tb_fib_sweep_ctrl: drives fib_sweep_ctrl with a behavioural Fibonacci core and a
// valid/ready consumer, comparing the result stream against a reference model.
module tb_fib_sweep_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic [3:0]  lo_n;
  logic [3:0]  hi_n;
  logic        fib_start;
  logic [3:0]  fib_n;
  logic        fib_ready;
  logic [10:0] fib_out;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_n;
  logic [10:0] res_data;
  logic        res_err;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        bad_cfg;
  logic [3:0]  err_count;

  fib_sweep_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .lo_n(lo_n), .hi_n(hi_n),
    .fib_start(fib_start), .fib_n(fib_n), .fib_ready(fib_ready), .fib_out(fib_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_n(res_n), .res_data(res_data),
    .res_err(res_err), .busy(busy), .done(done), .timeout(timeout), .bad_cfg(bad_cfg),
    .err_count(err_count)
  );

  typedef struct {
    int lo;
    int hi;
    int cor;
    bit inject;
    int expBad;
    int expEntries;
    int expErr;
  } vec_t;

  int totalChecks = 0;
  int badChecks   = 0;

  // expected result stream, written by the model and consumed by the scoreboard
  int expN    [1024];
  int expData [1024];
  int expErr  [1024];
  int wrIdx = 0;
  int rxIdx = 0;

  int startCnt = 0;
  int doneCnt  = 0;
  int badCnt   = 0;

  int readyMode = 0;   // 0: always ready, 1: never ready, 2: random
  bit stuckMode = 0;
  int corruptN  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalChecks++;
    if (actual != expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    totalChecks++;
    badChecks++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  function automatic int fibVal(input int n);
    int a = 0;
    int b = 1;
    int t;
    for (int k = 0; k < n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Reference model: the values the core will return and the recurrence verdicts.
  task automatic modelSweep(input int lo, input int hi, input int cor,
                            output int nEntries, output int nErr, output bit isBad);
    int p1;
    int p2;
    int caps;
    int v;
    bit e;
    p1 = 0; p2 = 0; caps = 0;
    nEntries = 0;
    nErr = 0;
    isBad = !((lo >= 2) && (lo <= hi));
    if (!isBad) begin
      for (int n = lo; n <= hi; n++) begin
        v = fibVal(n) + ((n == cor) ? 1 : 0);
        e = (caps >= 2) && (v != p1 + p2);
        expN[wrIdx]    = n;
        expData[wrIdx] = v;
        expErr[wrIdx]  = int'(e);
        wrIdx++;
        nEntries++;
        if (e && nErr < 15) nErr++;
        p2 = p1;
        p1 = v;
        caps++;
      end
    end
  endtask

  // Behavioural core: drops ready after a start, returns F(n) a few cycles later.
  task automatic coreModel();
    int n;
    int lat;
    forever begin
      @(negedge clk);
      if (fib_start && !stuckMode) begin
        n = int'(fib_n);
        fib_ready = 1'b0;
        fib_out = 11'($urandom_range(0, 2047));
        lat = $urandom_range(4, 7);
        repeat (lat) @(negedge clk);
        fib_out = 11'(fibVal(n) + ((n == corruptN) ? 1 : 0));
        fib_ready = 1'b1;
      end
    end
  endtask

  // Consumer and scoreboard: checks each transfer in order and the hold-under-stall rule.
  task automatic consumer();
    bit prevStall = 0;
    int pN = 0;
    int pD = 0;
    int pE = 0;
    forever begin
      @(negedge clk);
      case (readyMode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'b0;
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
      if (prevStall && res_valid) begin
        checkOutput("hold res_n", int'(res_n), pN);
        checkOutput("hold res_data", int'(res_data), pD);
        checkOutput("hold res_err", int'(res_err), pE);
      end
      if (res_valid && res_ready) begin
        if (rxIdx < wrIdx) begin
          checkOutput("entry n", int'(res_n), expN[rxIdx]);
          checkOutput("entry data", int'(res_data), expData[rxIdx]);
          checkOutput("entry err", int'(res_err), expErr[rxIdx]);
        end else begin
          failNow("unexpected entry");
        end
        rxIdx++;
      end
      prevStall = res_valid && !res_ready;
      pN = int'(res_n);
      pD = int'(res_data);
      pE = int'(res_err);
    end
  endtask

  // Pulse counters for start/done/bad_cfg; done must coincide with busy low.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (fib_start) startCnt++;
      if (bad_cfg) badCnt++;
      if (done) begin
        doneCnt++;
        checkOutput("busy low with done", int'(busy), 0);
      end
    end
  endtask

  task automatic pulseGo(input int lo, input int hi);
    @(negedge clk);
    go = 1'b1;
    lo_n = 4'(lo);
    hi_n = 4'(hi);
    @(negedge clk);
    go = 1'b0;
    lo_n = 4'($urandom);
    hi_n = 4'($urandom);
  endtask

  task automatic waitSweepEnd(input string name);
    int cyc;
    for (cyc = 0; cyc < 3000 && !(!busy && rxIdx == wrIdx); cyc++) @(negedge clk);
    if (cyc == 3000) failNow(name);
    repeat (3) @(negedge clk);
  endtask

  // One go request plus the whole sweep it triggers; reports what was observed.
  task automatic applyStimulus(input int lo, input int hi, input int cor, input bit inject,
                               output int gotEntries, output int gotStarts,
                               output int gotBad, output int gotDone,
                               output int mEntries, output int mErr, output bit mBad);
    int baseRx = rxIdx;
    int baseStart = startCnt;
    int baseBad = badCnt;
    int baseDone = doneCnt;
    corruptN = cor;
    modelSweep(lo, hi, cor, mEntries, mErr, mBad);
    pulseGo(lo, hi);
    checkOutput("busy after go", int'(busy), int'(!mBad));
    checkOutput("fib_start after go", int'(fib_start), int'(!mBad));
    checkOutput("bad_cfg after go", int'(bad_cfg), int'(mBad));
    if (!mBad) begin
      checkOutput("timeout cleared", int'(timeout), 0);
      checkOutput("fib_n first", int'(fib_n), lo);
      checkOutput("err_count cleared", int'(err_count), 0);
    end
    @(negedge clk);
    checkOutput("fib_start one cycle", int'(fib_start), 0);
    if (inject) begin
      repeat (3) @(negedge clk);
      pulseGo(3, 3);
      repeat (3) @(negedge clk);
      pulseGo(7, 3);
    end
    waitSweepEnd("sweep completion");
    gotEntries = rxIdx - baseRx;
    gotStarts  = startCnt - baseStart;
    gotBad     = badCnt - baseBad;
    gotDone    = doneCnt - baseDone;
  endtask

  vec_t vecs[13];

  initial begin
    int gE, gS, gB, gD, mE, mR;
    bit mB;
    int baseStart, baseRx, baseDone, cyc, lo, hi, cor;

    rst_n = 1'b0; go = 1'b0; lo_n = '0; hi_n = '0;
    fib_ready = 1'b1; fib_out = '0; res_ready = 1'b0;

    vecs[0]  = '{2,  6,  0, 0, 0, 5,  0};
    vecs[1]  = '{2,  8,  5, 0, 0, 7,  3};
    vecs[2]  = '{7,  3,  0, 0, 1, 0,  0};
    vecs[3]  = '{1,  4,  0, 0, 1, 0,  0};
    vecs[4]  = '{5,  5,  0, 0, 0, 1,  0};
    vecs[5]  = '{3,  4,  0, 0, 0, 2,  0};
    vecs[6]  = '{0,  0,  0, 0, 1, 0,  0};
    vecs[7]  = '{15, 15, 0, 0, 0, 1,  0};
    vecs[8]  = '{2,  15, 0, 0, 0, 14, 0};
    vecs[9]  = '{2,  9,  2, 0, 0, 8,  1};
    vecs[10] = '{4,  12, 10, 0, 0, 9, 3};
    vecs[11] = '{2,  15, 15, 0, 0, 14, 1};
    vecs[12] = '{2,  7,  0, 1, 0, 6,  0};

    fork
      coreModel();
      consumer();
      monitor();
    join_none

    // reset state
    repeat (3) @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset fib_start", int'(fib_start), 0);
    checkOutput("reset fib_n", int'(fib_n), 0);
    checkOutput("reset res_valid", int'(res_valid), 0);
    checkOutput("reset timeout", int'(timeout), 0);
    checkOutput("reset err_count", int'(err_count), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset bad_cfg", int'(bad_cfg), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven sweeps, consumer always ready
    readyMode = 0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].lo, vecs[i].hi, vecs[i].cor, vecs[i].inject,
                    gE, gS, gB, gD, mE, mR, mB);
      checkOutput($sformatf("vec%0d entries", i), gE, vecs[i].expEntries);
      checkOutput($sformatf("vec%0d starts", i), gS, vecs[i].expEntries);
      checkOutput($sformatf("vec%0d bad_cfg", i), gB, vecs[i].expBad);
      checkOutput($sformatf("vec%0d done", i), gD, 1 - vecs[i].expBad);
      if (vecs[i].expBad == 0)
        checkOutput($sformatf("vec%0d err_count", i), int'(err_count), vecs[i].expErr);
    end

    // asynchronous reset in WAIT_DONE of the first n
    $display("[TB] reset during sweep");
    corruptN = 0;
    baseStart = startCnt;
    pulseGo(2, 6);
    for (cyc = 0; cyc < 50 && fib_ready; cyc++) @(negedge clk);
    if (cyc == 50) failNow("core busy wait");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset fib_n", int'(fib_n), 0);
    checkOutput("async reset fib_start", int'(fib_start), 0);
    checkOutput("async reset res_valid", int'(res_valid), 0);
    checkOutput("async reset res_data", int'(res_data), 0);
    checkOutput("async reset err_count", int'(err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("starts across reset", startCnt - baseStart, 1);
    checkOutput("fifo empty after reset", int'(res_valid), 0);

    // backpressure: FIFO fills, fifth result waits in PUSH
    $display("[TB] backpressure");
    readyMode = 1;
    repeat (2) @(negedge clk);
    corruptN = 0;
    baseStart = startCnt;
    baseRx = rxIdx;
    baseDone = doneCnt;
    modelSweep(2, 9, 0, mE, mR, mB);
    pulseGo(2, 9);
    repeat (120) @(negedge clk);
    checkOutput("stall starts", startCnt - baseStart, 5);
    checkOutput("stall busy", int'(busy), 1);
    checkOutput("stall res_valid", int'(res_valid), 1);
    checkOutput("stall head n", int'(res_n), 2);
    checkOutput("stall head data", int'(res_data), 1);
    checkOutput("stall nothing consumed", rxIdx - baseRx, 0);
    readyMode = 0;
    waitSweepEnd("backpressure drain");
    checkOutput("backpressure entries", rxIdx - baseRx, 8);
    checkOutput("backpressure starts", startCnt - baseStart, 8);
    checkOutput("backpressure done", doneCnt - baseDone, 1);

    // stuck core: ready never drops
    $display("[TB] stuck core");
    stuckMode = 1;
    baseStart = startCnt;
    baseRx = rxIdx;
    baseDone = doneCnt;
    pulseGo(3, 5);
    for (cyc = 0; cyc < 200 && busy; cyc++) @(negedge clk);
    if (cyc == 200) failNow("stuck core abort");
    checkOutput("stuck busy cycles", cyc, TIMEOUT + 1);
    checkOutput("stuck timeout", int'(timeout), 1);
    checkOutput("stuck busy", int'(busy), 0);
    checkOutput("stuck starts", startCnt - baseStart, 1);
    repeat (5) @(negedge clk);
    checkOutput("stuck no entry", rxIdx - baseRx, 0);
    checkOutput("stuck no done", doneCnt - baseDone, 0);
    checkOutput("stuck timeout sticky", int'(timeout), 1);
    stuckMode = 0;
    applyStimulus(2, 4, 0, 0, gE, gS, gB, gD, mE, mR, mB);
    checkOutput("after timeout entries", gE, 3);
    checkOutput("after timeout flag", int'(timeout), 0);

    // randomized sweeps with a random consumer
    $display("[TB] random sweeps");
    readyMode = 2;
    for (int r = 0; r < 10; r++) begin
      lo = $urandom_range(0, 15);
      hi = $urandom_range(0, 15);
      if ((r % 3) != 0 && !((lo >= 2) && (lo <= hi))) begin
        lo = $urandom_range(2, 15);
        hi = $urandom_range(lo, 15);
      end
      cor = $urandom_range(0, 15);
      applyStimulus(lo, hi, cor, 0, gE, gS, gB, gD, mE, mR, mB);
      checkOutput($sformatf("rnd%0d entries", r), gE, mE);
      checkOutput($sformatf("rnd%0d starts", r), gS, mE);
      checkOutput($sformatf("rnd%0d bad_cfg", r), gB, int'(mB));
      checkOutput($sformatf("rnd%0d done", r), gD, int'(!mB));
      if (!mB)
        checkOutput($sformatf("rnd%0d err_count", r), int'(err_count), mR);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/fib_sweep_ctrl.md
# fib_sweep_ctrl

Upstream controller and downstream result collector for the iterative Fibonacci core. On a `go` pulse it sweeps n over [lo_n, hi_n] and, for each n, issues one `start` to the core, waits for the core's busy/ready cycle and captures its 11-bit result. It checks each result against the recurrence F(k) = F(k-1) + F(k-2) and streams {n, value, err} out through a small FIFO with valid/ready handshake.

## Interface
- DEPTH, 4: result FIFO entries; power of two, ≥2.
- TIMEOUT, 31: maximum cycles spent in either core-wait state before the sweep aborts.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle request to start a sweep; sampled in IDLE only.
- lo_n  in  4  first n of the sweep; sampled with go.
- hi_n  in  4  last n of the sweep; sampled with go.
- fib_start  out  1  registered start pulse to the core.
- fib_n  out  4  registered n to the core; stable from ISSUE through capture.
- fib_ready  in  1  core ready; high when the core is idle.
- fib_out  in  11  core result.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer ready; a transfer occurs when res_valid and res_ready are both high.
- res_n  out  4  n of the head entry.
- res_data  out  11  result of the head entry.
- res_err  out  1  recurrence mismatch flag of the head entry.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when the sweep's last entry is written.
- timeout  out  1  sticky; set on abort, cleared by the next accepted go.
- bad_cfg  out  1  one-cycle pulse when go is rejected for an invalid range.
- err_count  out  4  count of mismatches in the current sweep; saturates at 15; cleared by an accepted go.

## Operation
- Reset value: every output is 0 and the FIFO is empty. Reset is asynchronous and can abort a sweep at any point; fib_start drops immediately.
- IDLE
  - A go is accepted when lo_n ≥ 2 and lo_n ≤ hi_n. On acceptance, latch the range, set cur = lo_n, clear err_count, timeout and the history, then go to ISSUE.
  - Otherwise, pulse bad_cfg and stay in IDLE.
  - go in any other state is ignored.
- ISSUE: fib_start = 1 for exactly this one cycle and fib_n = cur. Go to WAIT_BUSY.
- WAIT_BUSY: wait for fib_ready = 0, then go to WAIT_DONE.
- WAIT_DONE: wait for fib_ready = 1. In the same cycle, capture fib_out into cap, then go to PUSH.
- Timeout in either wait state: a per-state counter reaches TIMEOUT. Set timeout, discard the sweep remainder and go to IDLE. Entries already in the FIFO remain.
- PUSH
  - Write {cur, cap, err} when the FIFO count < DEPTH, evaluated on the registered count.
  - A pop in the same cycle does not free space for this push. PUSH stalls until space is available.
  - After the write: if cur == hi_n, pulse done and go to IDLE. Otherwise cur += 1 and go to ISSUE.
- Recurrence check
  - Keep p1 and p2, the last two captured values of the current sweep.
  - err = 0 for the first two captures of a sweep.
  - Afterwards, err = ({1'b0, cap} != p1 + p2), using a 12-bit sum with no wrap.
  - On every capture, shift the history: p2 ← p1, p1 ← cap. Corrupted values enter the history.
  - Each err = 1 increments err_count, saturating at 15.
- FIFO
  - First-in first-out. Head outputs are valid whenever count > 0.
  - res_n, res_data and res_err hold while res_valid is high and res_ready is low.
  - A simultaneous push and pop when not full leaves count unchanged.

## Timing
- go accepted at edge t: busy = 1 and fib_start = 1 after t. fib_start = 0 from t+1.
- Capture occurs on the first edge where fib_ready is sampled high in WAIT_DONE. The write occurs on the next edge when space is available.
- With no stalls, per-n overhead is 3 cycles plus the core compute time.
- done rises on the same edge as the final write, together with busy falling.
- A written entry is visible on res_valid the cycle after the write edge; there is no FIFO bypass.

## Test plan
- Reset: assert rst_n = 0 mid-sweep (in WAIT_DONE) -> all outputs 0 asynchronously, FIFO empty, no further fib_start.
- Nominal sweep, with a correct behavioural core and res_ready = 1: go, lo = 2, hi = 6 ->
  - 5 fib_start pulses and 5 entries with n = 2..6 in order;
  - all res_err = 0, err_count = 0;
  - one done pulse, busy = 0 afterwards.
- Backpressure: res_ready = 0, lo = 2, hi = 9 ->
  - 4 entries fill the FIFO; the 5th is captured and the block stalls in PUSH;
  - exactly 5 fib_start pulses so far;
  - after releasing res_ready, all 8 entries arrive in order with no loss or duplication.
- Corrupt the core result at n = 5 (true value + 1), lo = 2, hi = 8 -> res_err = 1 for n = 5, 6 and 7, 0 elsewhere; err_count = 3.
- Stuck core: fib_ready held high after start -> after TIMEOUT cycles in WAIT_BUSY, timeout = 1, busy = 0, no entry written. The next valid go clears timeout.
- Bad configuration: go with lo = 7, hi = 3, then go with lo = 1, hi = 4 -> two bad_cfg pulses, no fib_start. A go pulsed during a valid sweep is ignored (the sweep completes unchanged).
